// File: rtl/vga_world_to_screen_if.sv
// Request/result bundle for vga_world_to_screen.
// W2S_CENTER_EN adds the cell-center outputs.
interface vga_world_to_screen_if;
  logic        req;
  logic [6:0]  world_row;
  logic [6:0]  world_column;
  logic        busy;
  logic        done;
  logic [11:0] pixel_row_start;
  logic [11:0] pixel_row_end;
  logic [11:0] pixel_col_start;
  logic [11:0] pixel_col_end;
  logic        off_screen;
`ifdef W2S_CENTER_EN
  logic [11:0] pixel_row_center;
  logic [11:0] pixel_col_center;

  modport master (
    output req, world_row, world_column,
    input  busy, done, pixel_row_start, pixel_row_end,
    input  pixel_col_start, pixel_col_end, off_screen,
    input  pixel_row_center, pixel_col_center
  );
  modport slave (
    input  req, world_row, world_column,
    output busy, done, pixel_row_start, pixel_row_end,
    output pixel_col_start, pixel_col_end, off_screen,
    output pixel_row_center, pixel_col_center
  );
`else
  modport master (
    output req, world_row, world_column,
    input  busy, done, pixel_row_start, pixel_row_end,
    input  pixel_col_start, pixel_col_end, off_screen
  );
  modport slave (
    input  req, world_row, world_column,
    output busy, done, pixel_row_start, pixel_row_end,
    output pixel_col_start, pixel_col_end, off_screen
  );
`endif
endinterface

// File: rtl/vga_world_to_screen.sv
// World cell -> screen pixel rectangle, computed by repeated addition (no multipliers).
// Optional macro W2S_CENTER_EN adds registered cell-center outputs.
//
//   state   | meaning
//   IDLE    | waiting for req; inputs captured on acceptance
//   CALC    | accumulating ratio steps until cnt reaches max(row, col)
//   DONE    | one-cycle done pulse, results valid
module vga_world_to_screen #(
  parameter int SCREEN_TO_WORLD_RATIO_COL = 6,
  parameter int SCREEN_TO_WORLD_RATIO_ROW = 6,
  parameter int WORLD_COLS                = 128,
  parameter int WORLD_ROWS                = 128,
  parameter int MARGIN                    = 128,
  parameter int SCREEN_COLS               = 1024,
  parameter int SCREEN_ROWS               = 768
) (
  input logic               clk,
  input logic               reset,
  vga_world_to_screen_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [6:0]  r_row, r_col, cnt, cnt_max;
  logic [11:0] row_acc, col_acc;
  logic [11:0] row_start_q, row_end_q, col_start_q, col_end_q;
  logic        off_q;

  // 32-bit intermediates keep the pre-wrap value so carries out of bit 11 are visible
  logic [31:0] row_end_w, col_start_w, col_end_w;
  logic        world_oob, off_next;

  assign cnt_max     = (r_row > r_col) ? r_row : r_col;
  assign row_end_w   = 32'(row_acc) + 32'(SCREEN_TO_WORLD_RATIO_ROW) - 32'd1;
  assign col_start_w = 32'(col_acc) + 32'(MARGIN);
  assign col_end_w   = col_start_w + 32'(SCREEN_TO_WORLD_RATIO_COL) - 32'd1;
  assign world_oob   = (32'(r_row) >= 32'(WORLD_ROWS)) | (32'(r_col) >= 32'(WORLD_COLS));
  assign off_next    = world_oob
                     | (row_end_w > 32'(SCREEN_ROWS - 1))
                     | (col_end_w > 32'(SCREEN_COLS - 1))
                     | (|row_end_w[31:12]) | (|col_end_w[31:12]);

`ifdef W2S_CENTER_EN
  logic [11:0] row_center_q, col_center_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      cnt         <= '0;
      row_acc     <= '0;
      col_acc     <= '0;
      row_start_q <= '0;
      row_end_q   <= '0;
      col_start_q <= '0;
      col_end_q   <= '0;
      off_q       <= 1'b0;
`ifdef W2S_CENTER_EN
      row_center_q <= '0;
      col_center_q <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            r_row   <= bus.world_row;
            r_col   <= bus.world_column;
            cnt     <= '0;
            row_acc <= '0;
            col_acc <= '0;
            state   <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (cnt == cnt_max) begin
            row_start_q <= row_acc;
            row_end_q   <= row_end_w[11:0];
            col_start_q <= col_start_w[11:0];
            col_end_q   <= col_end_w[11:0];
            off_q       <= off_next;
`ifdef W2S_CENTER_EN
            row_center_q <= row_acc + 12'(SCREEN_TO_WORLD_RATIO_ROW >> 1);
            col_center_q <= col_start_w[11:0] + 12'(SCREEN_TO_WORLD_RATIO_COL >> 1);
`endif
            state <= ST_DONE;
          end else begin
            if (cnt < r_row) row_acc <= row_acc + 12'(SCREEN_TO_WORLD_RATIO_ROW);
            if (cnt < r_col) col_acc <= col_acc + 12'(SCREEN_TO_WORLD_RATIO_COL);
            cnt <= cnt + 7'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy            = (state != ST_IDLE);
  assign bus.done            = (state == ST_DONE);
  assign bus.pixel_row_start = row_start_q;
  assign bus.pixel_row_end   = row_end_q;
  assign bus.pixel_col_start = col_start_q;
  assign bus.pixel_col_end   = col_end_q;
  assign bus.off_screen      = off_q;
`ifdef W2S_CENTER_EN
  assign bus.pixel_row_center = row_center_q;
  assign bus.pixel_col_center = col_center_q;
`endif
endmodule

// File: tb/tb_vga_world_to_screen.sv
// Scoreboard bench for vga_world_to_screen: default DUT plus one with SCREEN_ROWS=760.
module tb_vga_world_to_screen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_world_to_screen_if bus0 ();
  vga_world_to_screen_if bus1 ();

  vga_world_to_screen dut0 (.clk(clk), .reset(reset), .bus(bus0));
  vga_world_to_screen #(.SCREEN_ROWS(760)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    int rs, re, cs, ce, off, rc, cc, cyc_done;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop and compare whenever a DUT signals done
  always @(negedge clk) begin
    exp_t e;
    if (bus0.done) begin
      if (q0.size() == 0) chk("dut0_unexpected_done", 1, 0);
      else begin
        e = q0.pop_front();
        chk("dut0_row_start", int'(bus0.pixel_row_start), e.rs);
        chk("dut0_row_end",   int'(bus0.pixel_row_end),   e.re);
        chk("dut0_col_start", int'(bus0.pixel_col_start), e.cs);
        chk("dut0_col_end",   int'(bus0.pixel_col_end),   e.ce);
        chk("dut0_off",       int'(bus0.off_screen),      e.off);
        chk("dut0_done_cycle", cyc, e.cyc_done);
`ifdef W2S_CENTER_EN
        chk("dut0_row_center", int'(bus0.pixel_row_center), e.rc);
        chk("dut0_col_center", int'(bus0.pixel_col_center), e.cc);
`endif
      end
    end
    if (bus1.done) begin
      if (q1.size() == 0) chk("dut1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        chk("dut1_row_start", int'(bus1.pixel_row_start), e.rs);
        chk("dut1_row_end",   int'(bus1.pixel_row_end),   e.re);
        chk("dut1_col_start", int'(bus1.pixel_col_start), e.cs);
        chk("dut1_col_end",   int'(bus1.pixel_col_end),   e.ce);
        chk("dut1_off",       int'(bus1.off_screen),      e.off);
        chk("dut1_done_cycle", cyc, e.cyc_done);
      end
    end
  end

  task automatic drive(input int which, input bit r, input int row, input int col);
    if (which == 0) begin
      bus0.req = r; bus0.world_row = 7'(row); bus0.world_column = 7'(col);
    end else begin
      bus1.req = r; bus1.world_row = 7'(row); bus1.world_column = 7'(col);
    end
  endtask

  // Caller is #1 after a rising edge; req is held for exactly this cycle.
  task automatic issue(input int which, input int row, input int col,
                       input int rs, input int re, input int cs, input int ce,
                       input int off, input bit expect_done);
    exp_t e;
    drive(which, 1'b1, row, col);
    e.rs = rs; e.re = re; e.cs = cs; e.ce = ce; e.off = off;
    e.rc = rs + 3; e.cc = cs + 3;
    e.cyc_done = cyc + ((row > col) ? row : col) + 2;
    if (expect_done) begin
      if (which == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk); #1;
    drive(which, 1'b0, 0, 0);
  endtask

  task automatic wait_idle(input int which);
    bit idle = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      @(negedge clk);
      idle = (which == 0) ? !bus0.busy : !bus1.busy;
    end
    if (!idle) chk("wait_idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_row_start"}, int'(bus0.pixel_row_start), 0);
    chk({tag, "_row_end"},   int'(bus0.pixel_row_end),   0);
    chk({tag, "_col_start"}, int'(bus0.pixel_col_start), 0);
    chk({tag, "_col_end"},   int'(bus0.pixel_col_end),   0);
    chk({tag, "_off"},       int'(bus0.off_screen),      0);
    chk({tag, "_busy"},      int'(bus0.busy),            0);
    chk({tag, "_done"},      int'(bus0.done),            0);
  endtask

  initial begin
    int n;
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // (0,0): two-cycle latency, busy across N+1..N+2
    issue(0, 0, 0, 0, 5, 128, 133, 0, 1'b1);
    @(negedge clk); chk("busy_n1", int'(bus0.busy), 1);
    @(negedge clk); chk("busy_n2", int'(bus0.busy), 1);
    wait_idle(0);

    // Far corner of the world
    issue(0, 127, 127, 762, 767, 890, 895, 0, 1'b1);
    wait_idle(0);

    // Default screen: bottom row still fits
    issue(0, 127, 0, 762, 767, 128, 133, 0, 1'b1);
    wait_idle(0);

    // Shorter screen: row 127 and 126 overflow, 125 fits
    issue(1, 127, 0, 762, 767, 128, 133, 1, 1'b1);
    wait_idle(1);
    issue(1, 126, 0, 756, 761, 128, 133, 1, 1'b1);
    wait_idle(1);
    issue(1, 125, 0, 750, 755, 128, 133, 0, 1'b1);
    wait_idle(1);

    // (10,3) with stray reqs in CALC and DONE; fresh req right after done
    n = cyc;
    issue(0, 10, 3, 60, 65, 146, 151, 0, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    drive(0, 1'b1, 0, 0);
    @(posedge clk); #1;
    drive(0, 1'b0, 99, 99);
    while (cyc < n + 12) begin @(posedge clk); #1; end
    drive(0, 1'b1, 1, 1);
    @(posedge clk); #1;
    issue(0, 2, 2, 12, 17, 140, 145, 0, 1'b1);
    wait_idle(0);

    // Reset mid-CALC aborts the conversion without a done pulse
    issue(0, 100, 100, 0, 0, 0, 0, 0, 1'b0);
    repeat (20) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk_zero("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (120) begin @(posedge clk); #1; end
    issue(0, 2, 2, 12, 17, 140, 145, 0, 1'b1);
    wait_idle(0);

    repeat (3) @(posedge clk);
    chk("dut0_pending", q0.size(), 0);
    chk("dut1_pending", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_world_to_screen.md
Name: vga_world_to_screen

Overview:
- Inverse of the screen-to-world scaler: converts a world map cell (world_row, world_column) into the screen-pixel rectangle that the cell occupies.
- The rectangle is computed with an iterative shift-free accumulate FSM (no multipliers) behind a req/done handshake.
- Feeds the robot-icon and overlay logic so they can compare the current pixel_row/pixel_column against a registered bounding box.

Parameters:
SCREEN_TO_WORLD_RATIO_COL, 6, screen pixels per world column
SCREEN_TO_WORLD_RATIO_ROW, 6, screen pixels per world row
WORLD_COLS, 128, number of valid world columns
WORLD_ROWS, 128, number of valid world rows
MARGIN, 128, horizontal pixel offset of world column 0 (no vertical offset)
SCREEN_COLS, 1024, visible screen width in pixels
SCREEN_ROWS, 768, visible screen height in pixels

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  1  conversion request; sampled only in IDLE
world_row  in  7  world row to convert; captured with req
world_column  in  7  world column to convert; captured with req
busy  out  1  high whenever FSM is not in IDLE
done  out  1  one-cycle pulse; outputs below valid from this cycle
pixel_row_start  out  12  first screen row of the cell
pixel_row_end  out  12  last screen row of the cell (inclusive)
pixel_col_start  out  12  first screen column of the cell
pixel_col_end  out  12  last screen column of the cell (inclusive)
off_screen  out  1  cell is outside the world or extends past the screen

Behaviour:
- Reset: all outputs 0 and FSM in IDLE. Reset asserted during CALC or DONE aborts the conversion; no done pulse is produced afterwards.
- States:
  - IDLE: if req=1, capture world_row/world_column into r_row/r_col, clear cnt and both accumulators, go to CALC. Otherwise stay.
  - CALC: if cnt == max(r_row, r_col), register the outputs and go to DONE. Otherwise:
    - if cnt < r_row: row_acc += RATIO_ROW
    - if cnt < r_col: col_acc += RATIO_COL
    - cnt++; stay in CALC.
  - DONE: done=1 for exactly this cycle; return to IDLE.
- Latency: if req is sampled in cycle N, done is high in cycle N + max(r_row, r_col) + 2. Example: (0,0) gives done at N+2; (127,5) gives done at N+129.
- Output arithmetic (12-bit, unsigned, wraps mod 4096):
  - pixel_row_start = row_acc
  - pixel_row_end = row_acc + RATIO_ROW - 1
  - pixel_col_start = MARGIN + col_acc
  - pixel_col_end = MARGIN + col_acc + RATIO_COL - 1
- off_screen = (r_row >= WORLD_ROWS) | (r_col >= WORLD_COLS) | (pixel_row_end > SCREEN_ROWS-1) | (pixel_col_end > SCREEN_COLS-1). It is evaluated from the pre-wrap value, so any carry out of bit 11 also forces off_screen=1.
- Outputs hold their last registered value until the next DONE. They are not cleared when the FSM returns to IDLE.
- req while busy=1 is ignored and not queued. This includes the DONE cycle; the earliest next acceptance is the cycle after done.
- busy = (state != IDLE); busy is high during the done cycle.
- A world input changing after capture has no effect on the conversion in progress.

Optional Feature:
- Macro W2S_CENTER_EN.
- Defined: adds outputs pixel_row_center[11:0] = pixel_row_start + (RATIO_ROW>>1) and pixel_col_center[11:0] = pixel_col_start + (RATIO_COL>>1). They are registered on the same edge as the other outputs, reset to 0, and hold between conversions.
- Undefined: neither port exists and no center logic is synthesized. All other behaviour is identical.

Test Plan:
- Reset, then req with (row=0, col=0) in cycle N -> done at N+2; row 0..5, col 128..133, off_screen=0, busy high in N+1..N+2.
- req with (row=127, col=127) -> done after 129 cycles; row 762..767, col 890..895, off_screen=0.
- Parameter SCREEN_ROWS=760, req with (row=127, col=0) -> row_end=767 > 759, so off_screen=1; start/end values still reported.
- req with (row=10, col=3) and a second req pulsed during CALC and during the DONE cycle -> exactly one done; outputs row 60..65, col 146..151; a fresh req the cycle after done is accepted.
- Reset asserted mid-CALC of (row=100, col=100) -> outputs 0, busy=0 the next cycle, no done pulse; a subsequent req for (2,2) gives row 12..17, col 140..145 at N+4.
- With W2S_CENTER_EN defined, (row=10, col=3) -> pixel_row_center=63, pixel_col_center=149.
